rom_ctrl: RTL
=============

// Module: rom_ctrl
// PURPOSE
// Responder end of the mapper PRG/CHR ROM request interface (promaddr/promreq/promack/promdata, cromaddr/cromreq/cromack/cromdata).
// Translates mapper-relative ROM addresses to iNES image addresses using the 128-bit header.
// Arbitrates both clients onto one byte-wide backing-memory read port. Sits between the mapper mux and the ROM image memory.
// PARAMETERS
// AW    24  width of backing-memory byte address
// BASE  0   byte address of the iNES header (image start) in backing memory
// PORTS
// clk       in   1    system clock
// resetn    in   1    asynchronous active-low reset
// header    in   128  iNES header, byte n = header[8n+7:8n]; stable while requests are active
// promaddr  in   21   PRG ROM byte offset; stable while promreq high
// promreq   in   1    PRG read request (level)
// promack   out  1    PRG completion, one-cycle pulse
// promdata  out  8    PRG read data; valid with promack, held until next PRG ack
// cromaddr  in   21   CHR ROM byte offset; stable while cromreq high
// cromreq   in   1    CHR read request (level)
// cromack   out  1    CHR completion, one-cycle pulse
// cromdata  out  8    CHR read data; valid with cromack, held until next CHR ack
// ramaddr   out  AW   backing-memory byte address; stable while ramreq high
// ramreq    out  1    backing-memory read request (level, held until ramack)
// ramack    in   1    backing-memory completion pulse; ramrdata valid same cycle
// ramrdata  in   8    backing-memory read data
// oor       out  1    sticky: a request fell outside its ROM region
// BEHAVIOUR
// - Reset (async): state IDLE, ramreq=0, ramaddr=0, promack=cromack=0, promdata=cromdata=0, oor=0, last-grant=CHR.
// - Address map (combinational from header, widths zero-extended, sum truncated to AW):
//   prgbase = BASE + 16 + (header[50] ? 512 : 0); prgsize = header[39:32] << 14 (22 bits);
//   chrbase = prgbase + prgsize; chrsize = header[47:40] << 13 (21 bits).
// - In range: promaddr < prgsize -> ramaddr = prgbase + promaddr; cromaddr < chrsize -> ramaddr = chrbase + cromaddr.
// - FSM IDLE/BUSY/RESP, one outstanding transaction.
//   IDLE: no req -> IDLE. One req -> grant it. Both -> grant the one not in last-grant (round-robin); update last-grant.
//     Granted in range -> register ramaddr, ramreq=1, go BUSY.
//     Granted out of range -> latch data 8'hFF, set oor, go RESP; no backing access.
//   BUSY: hold ramreq/ramaddr; on ramack -> latch ramrdata into the granted client's data reg, ramreq=0, go RESP.
//   RESP: pulse the granted client's ack for exactly this cycle; go IDLE.
// - Latency: req seen in IDLE cycle N -> ramreq at N+1; ramack in cycle M (M>=N+1) -> client ack at M+1. Min 2 cycles.
//   Out-of-range ack at N+1.
// - Client rule: deassert req in the cycle after ack unless issuing a new request. Req still high in the IDLE after RESP is a new request.
// - Non-granted request waits in place; its address must stay stable. Requests dropped before grant are not served.
// - Header 0 in PRG/CHR size field (e.g. CHR RAM cart, byte5=0): every request to that region is out of range.
// - Acks never overlap; at most one of promack/cromack high in any cycle.
// - Reset mid-transaction: ramreq drops immediately and no ack is issued. Backend must abandon the in-flight read.
// - oor clears only on reset.
// TESTING
// - byte4=2, byte5=1, trainer=0, BASE=0, zero-wait memory; promreq with promaddr=0 -> ramaddr=0x10; promack 2 cycles after req; promdata=mem[0x10].
// - Same with header[50]=1, promaddr=0x7FFF -> ramaddr=0x820F; cromaddr=0x1234 -> ramaddr=0x8210+0x1234=0x9444.
// - promreq and cromreq held continuously from reset -> grants alternate PRG,CHR,PRG,CHR; acks never coincide.
// - byte5=0, cromreq addr 0 -> cromack 1 cycle later, cromdata=8'hFF, oor=1, ramreq never asserted.
// - Backend stalls ramack 5 cycles -> ramaddr/ramreq stable throughout; ack exactly 1 cycle after ramack.
// - Assert resetn=0 during BUSY -> ramreq, acks, oor go 0 asynchronously; after release, first request served normally.

Source files
------------

// File: rtl/rom_ctrl.sv
// rom_ctrl: serves mapper PRG/CHR ROM reads from a single byte-wide backing
// memory. Offsets are mapped to iNES image addresses using the header, and the
// two clients share the memory port under round-robin arbitration.
module rom_ctrl #(
  parameter int unsigned   AW   = 24,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [127:0]  header,
  input  logic [20:0]   promaddr,
  input  logic          promreq,
  output logic          promack,
  output logic [7:0]    promdata,
  input  logic [20:0]   cromaddr,
  input  logic          cromreq,
  output logic          cromack,
  output logic [7:0]    cromdata,
  output logic [AW-1:0] ramaddr,
  output logic          ramreq,
  input  logic          ramack,
  input  logic [7:0]    ramrdata,
  output logic          oor
);

  localparam int unsigned RW  = 21;  // client offset / CHR size width
  localparam int unsigned PSW = 22;  // PRG size width

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nx;
  logic          last_chr, last_chr_nx;  // 1: CHR was granted most recently
  logic          pick_chr;
  logic [AW-1:0] ramaddr_nx;
  logic          ramreq_nx, promack_nx, cromack_nx, oor_nx;
  logic [7:0]    promdata_nx, cromdata_nx;

  logic [PSW-1:0] prgsize;
  logic [RW-1:0]  chrsize;
  logic [AW-1:0]  prgbase, chrbase;
  logic           prg_in, chr_in;
  logic           header_unused;

  // Image layout: 16-byte header, optional 512-byte trainer, PRG, then CHR
  assign prgsize = {header[39:32], 14'b0};
  assign chrsize = {header[47:40], 13'b0};
  assign prgbase = BASE + AW'(16) + (header[50] ? AW'(512) : AW'(0));
  assign chrbase = prgbase + AW'(prgsize);
  assign prg_in  = PSW'(promaddr) < prgsize;
  assign chr_in  = cromaddr < chrsize;

  assign header_unused = ^{header[127:51], header[49:48], header[31:0]};

  // Next-state and next-output logic: arbitration, mapping and completion
  always_comb begin
    state_nx    = state;
    last_chr_nx = last_chr;
    pick_chr    = 1'b0;
    ramaddr_nx  = ramaddr;
    ramreq_nx   = ramreq;
    promack_nx  = 1'b0;
    cromack_nx  = 1'b0;
    promdata_nx = promdata;
    cromdata_nx = cromdata;
    oor_nx      = oor;
    case (state)
      IDLE: begin
        if (promreq || cromreq) begin
          pick_chr    = cromreq && (!promreq || !last_chr);
          last_chr_nx = pick_chr;
          if (pick_chr ? chr_in : prg_in) begin
            ramaddr_nx = pick_chr ? (chrbase + AW'(cromaddr))
                                  : (prgbase + AW'(promaddr));
            ramreq_nx  = 1'b1;
            state_nx   = BUSY;
          end else begin
            // Out-of-region read: answer with 8'hFF without touching memory
            if (pick_chr) begin
              cromdata_nx = 8'hFF;
              cromack_nx  = 1'b1;
            end else begin
              promdata_nx = 8'hFF;
              promack_nx  = 1'b1;
            end
            oor_nx   = 1'b1;
            state_nx = RESP;
          end
        end
      end
      BUSY: begin
        if (ramack) begin
          ramreq_nx = 1'b0;
          if (last_chr) begin
            cromdata_nx = ramrdata;
            cromack_nx  = 1'b1;
          end else begin
            promdata_nx = ramrdata;
            promack_nx  = 1'b1;
          end
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      last_chr <= 1'b1;
      ramaddr  <= '0;
      ramreq   <= 1'b0;
      promack  <= 1'b0;
      cromack  <= 1'b0;
      promdata <= 8'h00;
      cromdata <= 8'h00;
      oor      <= 1'b0;
    end else begin
      state    <= state_nx;
      last_chr <= last_chr_nx;
      ramaddr  <= ramaddr_nx;
      ramreq   <= ramreq_nx;
      promack  <= promack_nx;
      cromack  <= cromack_nx;
      promdata <= promdata_nx;
      cromdata <= cromdata_nx;
      oor      <= oor_nx;
    end
  end

endmodule
